// File: rtl/dma_gp_channel_if.sv
// Bus bundle for the general-purpose DMA channel: CPU register port, control, A-bus and B-bus.
// The abort input exists only when DMA_ABORT_EN is defined.
interface dma_gp_channel_if;
  logic [2:0]  reg_sel;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        start;
  logic        busy;
  logic        done;
  logic [23:0] a_addr;
  logic        a_read;
  logic        a_write;
  logic [7:0]  a_rdata;
  logic [7:0]  a_wdata;
  logic [7:0]  b_addr;
  logic        b_read;
  logic        b_write;
  logic [7:0]  b_rdata;
  logic [7:0]  b_wdata;
`ifdef DMA_ABORT_EN
  logic        abort;

  modport master (
    input  reg_sel, reg_we, reg_wdata, start, abort, a_rdata, b_rdata,
    output reg_rdata, busy, done, a_addr, a_read, a_write, a_wdata,
           b_addr, b_read, b_write, b_wdata
  );
  modport slave (
    output reg_sel, reg_we, reg_wdata, start, abort, a_rdata, b_rdata,
    input  reg_rdata, busy, done, a_addr, a_read, a_write, a_wdata,
           b_addr, b_read, b_write, b_wdata
  );
`else
  modport master (
    input  reg_sel, reg_we, reg_wdata, start, a_rdata, b_rdata,
    output reg_rdata, busy, done, a_addr, a_read, a_write, a_wdata,
           b_addr, b_read, b_write, b_wdata
  );
  modport slave (
    output reg_sel, reg_we, reg_wdata, start, a_rdata, b_rdata,
    input  reg_rdata, busy, done, a_addr, a_read, a_write, a_wdata,
           b_addr, b_read, b_write, b_wdata
  );
`endif
endinterface

// File: rtl/dma_gp_channel.sv
// General-purpose DMA channel moving bytes between the 24-bit A-bus and the 8-bit B-bus.
// Optional feature macro: DMA_ABORT_EN (adds an abort input that ends a transfer early).
module dma_gp_channel (
  input  logic             clk,
  input  logic             reset,
  dma_gp_channel_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  ctrl_reg;
  logic [7:0]  baddr_reg;
  logic [15:0] aaddr_reg;
  logic [7:0]  abank_reg;
  logic [15:0] count_reg;
  logic [1:0]  unit_idx_reg;
  logic        done_reg;

  logic        dir, dec, fix;
  logic [2:0]  mode;
  logic        is_idle, cfg_we, start_ok, last_byte, abort_hit, end_xfer;
  logic [1:0]  b_offset;
  logic [15:0] aaddr_step;

  assign dir       = ctrl_reg[7];
  assign dec       = ctrl_reg[4];
  assign fix       = ctrl_reg[3];
  assign mode      = ctrl_reg[2:0];
  assign is_idle   = (state_reg == ST_IDLE);
  assign cfg_we    = bus.reg_we && is_idle;
  assign start_ok  = bus.start && is_idle;
  assign last_byte = (count_reg == 16'd1);
  assign end_xfer  = last_byte || abort_hit;

`ifdef DMA_ABORT_EN
  logic abort_pending_reg;

  // An abort seen during RD is remembered so the byte still finishes its WR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      abort_pending_reg <= 1'b0;
    else if (state_reg == ST_RD && bus.abort)
      abort_pending_reg <= 1'b1;
    else if (state_reg != ST_RD)
      abort_pending_reg <= 1'b0;
  end

  assign abort_hit = bus.abort || abort_pending_reg;
`else
  assign abort_hit = 1'b0;
`endif

  // B offset pattern; every mode repeats within four units, so a 2-bit index suffices.
  always_comb begin
    b_offset = 2'd0;
    unique case (mode)
      3'd1, 3'd5: b_offset = {1'b0, unit_idx_reg[0]};
      3'd3, 3'd7: b_offset = {1'b0, unit_idx_reg[1]};
      3'd4:       b_offset = unit_idx_reg;
      default:    b_offset = 2'd0;
    endcase
  end

  assign aaddr_step = fix ? aaddr_reg :
                      (dec ? aaddr_reg - 16'd1 : aaddr_reg + 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    bus.a_read  = 1'b0;
    bus.a_write = 1'b0;
    bus.b_read  = 1'b0;
    bus.b_write = 1'b0;
    bus.a_addr  = {abank_reg, aaddr_reg};
    bus.b_addr  = baddr_reg;
    bus.a_wdata = 8'h00;
    bus.b_wdata = 8'h00;
    unique case (state_reg)
      ST_IDLE: begin
        if (start_ok)
          state_next = ST_RD;
      end
      ST_RD: begin
        bus.b_addr = baddr_reg + {6'd0, b_offset};
        if (dir)
          bus.b_read = 1'b1;
        else
          bus.a_read = 1'b1;
        state_next = ST_WR;
      end
      ST_WR: begin
        // Responders return data one cycle after the strobe; forward it straight through.
        bus.b_addr = baddr_reg + {6'd0, b_offset};
        if (dir) begin
          bus.a_write = 1'b1;
          bus.a_wdata = bus.b_rdata;
        end else begin
          bus.b_write = 1'b1;
          bus.b_wdata = bus.a_rdata;
        end
        state_next = end_xfer ? ST_IDLE : ST_RD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg     <= 8'h00;
      baddr_reg    <= 8'h00;
      aaddr_reg    <= 16'h0000;
      abank_reg    <= 8'h00;
      count_reg    <= 16'h0000;
      unit_idx_reg <= 2'd0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cfg_we) begin
        unique case (bus.reg_sel)
          3'd0:    ctrl_reg          <= bus.reg_wdata;
          3'd1:    baddr_reg         <= bus.reg_wdata;
          3'd2:    aaddr_reg[7:0]    <= bus.reg_wdata;
          3'd3:    aaddr_reg[15:8]   <= bus.reg_wdata;
          3'd4:    abank_reg         <= bus.reg_wdata;
          3'd5:    count_reg[7:0]    <= bus.reg_wdata;
          3'd6:    count_reg[15:8]   <= bus.reg_wdata;
          default: ;
        endcase
      end
      if (start_ok)
        unit_idx_reg <= 2'd0;
      // A count of 0 decrements to FFFF and keeps going, giving 65536 bytes.
      if (state_reg == ST_WR) begin
        count_reg    <= count_reg - 16'd1;
        aaddr_reg    <= aaddr_step;
        unit_idx_reg <= unit_idx_reg + 2'd1;
        if (end_xfer)
          done_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.reg_rdata = 8'h00;
    unique case (bus.reg_sel)
      3'd0:    bus.reg_rdata = ctrl_reg;
      3'd1:    bus.reg_rdata = baddr_reg;
      3'd2:    bus.reg_rdata = aaddr_reg[7:0];
      3'd3:    bus.reg_rdata = aaddr_reg[15:8];
      3'd4:    bus.reg_rdata = abank_reg;
      3'd5:    bus.reg_rdata = count_reg[7:0];
      3'd6:    bus.reg_rdata = count_reg[15:8];
      default: bus.reg_rdata = 8'h00;
    endcase
  end

  assign bus.busy = !is_idle;
  assign bus.done = done_reg;

endmodule
